uart_rx_deser: RTL

UART receive deserializer that sits directly upstream of the UART loader stage. It samples the asynchronous serial line and recovers 8N1 frames, or 8E1 frames when parity is compiled in. Each good byte is delivered as a single-cycle `uart_valid_o` pulse with `uart_byte_o`, which the loader assembles into 32-bit words and addresses. Framing and parity errors are flagged and the bad byte is never forwarded.

---
 rtl/uart_rx_deser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer feeding the UART loader stage.
// Define UART_RX_PARITY_EN to build the 8E1 variant with parity checking.
module uart_rx_deser #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] uart_byte_o,
    output logic       uart_valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          sync1, rx_s;
    logic          fire_v, fire_v_n;
    logic          fire_f, fire_f_n;
`ifdef UART_RX_PARITY_EN
    logic          perr_pend, perr_n;
    logic          fire_p, fire_p_n;
    logic          perr_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1        <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            fire_v       <= 1'b0;
            fire_f       <= 1'b0;
            uart_byte_o  <= '0;
            uart_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            sync1        <= rx_i;
            rx_s         <= sync1;
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= idx_n;
            shift        <= shift_n;
            fire_v       <= fire_v_n;
            fire_f       <= fire_f_n;
            uart_valid_o <= fire_v;
            frame_err_o  <= fire_f;
            if (fire_v) uart_byte_o <= shift;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perr_pend <= 1'b0;
            fire_p    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            perr_pend <= perr_n;
            fire_p    <= fire_p_n;
            perr_q    <= fire_p;
        end
    end
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign busy_o = (state != IDLE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = bit_idx;
        shift_n  = shift;
        fire_v_n = 1'b0;
        fire_f_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n   = perr_pend;
        fire_p_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
`ifdef UART_RX_PARITY_EN
                    perr_n  = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt == HALF) begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    idx_n            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    perr_n  = (rx_s != ^shift);
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                // Leave mid-stop-bit so an abutting start bit is caught
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        fire_f_n = 1'b1;
                        state_n  = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (perr_pend) begin
                        fire_p_n = 1'b1;
                        state_n  = IDLE;
`endif
                    end else begin
                        fire_v_n = 1'b1;
                        state_n  = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
